// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path.
// Used by the scheduler, the scan FSM and the digit counter.
// Pure declarations; no logic, no latency, no flow control.
package display_pkg;

  // Digits scanned per frame and width of one display word.
  localparam int DIGITS = 8;
  localparam int WORD_W = 32;

  // Scheduler states: waiting for a requester, or showing a granted word.
  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } sched_state_t;

endpackage

// File: rtl/display_sched_if.sv
// Request bus from NUM_SRC producers into the display scheduler.
// Valid/data are held by the producer until a one-cycle ready pulse.
// Ready is a single-cycle accept pulse; producers must not assume it persists.
interface display_sched_if
  import display_pkg::*;
#(
  parameter int NUM_SRC = 4
);

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0][WORD_W-1:0] src_data;
  logic [NUM_SRC-1:0]             src_ready;

  // Producers drive requests and watch for their accept pulse.
  modport master (
    output src_valid,
    output src_data,
    input  src_ready
  );

  // The scheduler samples requests and issues accept pulses.
  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready
  );

endinterface

// File: rtl/display_sched_rr_arbiter.sv
// Round-robin pick: first requester above last_grant, wrapping modulo NUM_SRC.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is used.
module rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_grant,
  output logic [NUM_SRC-1:0]         grant,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_SRC);

  // One extra bit so last_grant + offset never overflows before the wrap.
  logic [IW:0]   cand_w;
  logic [IW-1:0] cand;

  // Walk offsets 1..NUM_SRC from last_grant; the first live request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand_w    = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand_w = {1'b0, last_grant} + (IW+1)'(i);
      if (cand_w >= (IW+1)'(NUM_SRC)) begin
        cand_w = cand_w - (IW+1)'(NUM_SRC);
      end
      cand = cand_w[IW-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_sched.sv
// Round-robin scheduler sharing one 8-digit scan FSM among NUM_SRC requesters.
// Latency: request at edge t -> src_ready/write_ready/writeback after edge t.
// Backpressure: requests wait (valid held) while a value is shown; no grant in SHOW.
module display_sched
  import display_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int FRAME_W = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  display_sched_if.slave             src,
  input  logic [FRAME_W-1:0]         frames,
  input  logic                       hold,
  input  logic                       shift_strobe,
  output logic [WORD_W-1:0]          writeback,
  output logic                       write_ready,
  output logic                       rollover_flag,
  output logic [$clog2(NUM_SRC)-1:0] active_src,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_SRC);

  sched_state_t       state, state_nxt;
  logic [IW-1:0]      last_grant, last_grant_nxt;
  logic [FRAME_W-1:0] frames_eff, frames_eff_nxt;
  logic [FRAME_W-1:0] frame_cnt, frame_cnt_nxt;

  logic [WORD_W-1:0]  writeback_nxt;
  logic               write_ready_nxt;
  logic [NUM_SRC-1:0] src_ready_nxt;
  logic               rollover_nxt;
  logic [IW-1:0]      active_nxt;
  logic               busy_nxt;

  // Widened so frame_cnt+1 is compared unsaturated and frames_eff-1 never wraps.
  logic [FRAME_W:0]   cnt_plus1;
  logic [FRAME_W:0]   last_idx;

  logic [NUM_SRC-1:0] grant_oh;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req        (src.src_valid),
    .last_grant (last_grant),
    .grant      (grant_oh),
    .grant_idx  (grant_idx),
    .any        (grant_any)
  );

  // Next-state and next-output decode; every output is then registered.
  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    frames_eff_nxt  = frames_eff;
    frame_cnt_nxt   = frame_cnt;
    writeback_nxt   = writeback;
    write_ready_nxt = 1'b0;
    src_ready_nxt   = '0;
    rollover_nxt    = rollover_flag;
    active_nxt      = active_src;
    busy_nxt        = busy;
    cnt_plus1       = {1'b0, frame_cnt} + (FRAME_W+1)'(1);
    last_idx        = {1'b0, frames_eff} - (FRAME_W+1)'(1);

    case (state)
      IDLE: begin
        // shift_strobe is deliberately ignored here.
        if (grant_any) begin
          writeback_nxt   = src.src_data[grant_idx];
          src_ready_nxt   = grant_oh;
          write_ready_nxt = 1'b1;
          active_nxt      = grant_idx;
          last_grant_nxt  = grant_idx;
          frames_eff_nxt  = (frames == '0) ? FRAME_W'(1) : frames;
          frame_cnt_nxt   = '0;
          // frames of 0 or 1 both mean a single frame.
          rollover_nxt    = (frames <= FRAME_W'(1)) && !hold;
          busy_nxt        = 1'b1;
          state_nxt       = SHOW;
        end
      end

      SHOW: begin
        // rollover_flag only moves on strobes, so the scan FSM sees it stable
        // from its last-digit cycle through the following strobe.
        if (shift_strobe) begin
          if (rollover_flag) begin
            rollover_nxt = 1'b0;
            busy_nxt     = 1'b0;
            state_nxt    = IDLE;
          end else begin
            frame_cnt_nxt = (&frame_cnt) ? frame_cnt : frame_cnt + FRAME_W'(1);
            rollover_nxt  = (cnt_plus1 >= last_idx) && !hold;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset makes source 0 win first.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      last_grant    <= IW'(NUM_SRC - 1);
      frames_eff    <= FRAME_W'(1);
      frame_cnt     <= '0;
      writeback     <= '0;
      write_ready   <= 1'b0;
      src.src_ready <= '0;
      rollover_flag <= 1'b0;
      active_src    <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      frames_eff    <= frames_eff_nxt;
      frame_cnt     <= frame_cnt_nxt;
      writeback     <= writeback_nxt;
      write_ready   <= write_ready_nxt;
      src.src_ready <= src_ready_nxt;
      rollover_flag <= rollover_nxt;
      active_src    <= active_nxt;
      busy          <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_display_sched.sv
// Self-checking bench for display_sched with a spec-level reference model.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// Model: round-robin pick by offset search, rollover by strobe-count arithmetic.
module tb_display_sched;

  localparam int NUM_SRC = 4;
  localparam int FRAME_W = 16;

  logic        clk;
  logic        n_rst;
  logic [15:0] frames;
  logic        hold;
  logic        shift_strobe;
  logic [31:0] writeback;
  logic        write_ready;
  logic        rollover_flag;
  logic [1:0]  active_src;
  logic        busy;

  int checks;
  int failures;
  int m_last;

  display_sched_if #(.NUM_SRC(NUM_SRC)) bus ();

  display_sched #(
    .NUM_SRC (NUM_SRC),
    .FRAME_W (FRAME_W)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .src           (bus),
    .frames        (frames),
    .hold          (hold),
    .shift_strobe  (shift_strobe),
    .writeback     (writeback),
    .write_ready   (write_ready),
    .rollover_flag (rollover_flag),
    .active_src    (active_src),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pick: first valid index searching upward from last+1, wrapping.
  function automatic int pick(input logic [3:0] mask, input int last);
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (mask[(last + i) % NUM_SRC]) return (last + i) % NUM_SRC;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    shift_strobe = 1'b1;
    tick();
    shift_strobe = 1'b0;
  endtask

  task automatic apply_reset();
    n_rst         = 1'b0;
    bus.src_valid = '0;
    bus.src_data  = '0;
    frames        = '0;
    hold          = 1'b0;
    shift_strobe  = 1'b0;
    repeat (2) tick();
    n_rst  = 1'b1;
    m_last = NUM_SRC - 1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (writeback !== 32'h0) begin failures++; $display("FAIL reset_writeback got=%h exp=0", writeback); end
    checks++; if (write_ready !== 1'b0) begin failures++; $display("FAIL reset_write_ready got=%b exp=0", write_ready); end
    checks++; if (bus.src_ready !== 4'b0) begin failures++; $display("FAIL reset_src_ready got=%b exp=0", bus.src_ready); end
    checks++; if (rollover_flag !== 1'b0) begin failures++; $display("FAIL reset_rollover got=%b exp=0", rollover_flag); end
    checks++; if (active_src !== 2'd0) begin failures++; $display("FAIL reset_active_src got=%0d exp=0", active_src); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    frames          = 16'd3;
    bus.src_valid   = 4'b0100;
    bus.src_data[2] = 32'hDEADBEEF;
    tick();
    checks++; if (bus.src_ready !== 4'b0100) begin failures++; $display("FAIL single_src_ready got=%b exp=0100", bus.src_ready); end
    checks++; if (write_ready !== 1'b1) begin failures++; $display("FAIL single_write_ready got=%b exp=1", write_ready); end
    checks++; if (writeback !== 32'hDEADBEEF) begin failures++; $display("FAIL single_writeback got=%h exp=deadbeef", writeback); end
    checks++; if (active_src !== 2'd2) begin failures++; $display("FAIL single_active got=%0d exp=2", active_src); end
    checks++; if (rollover_flag !== 1'b0) begin failures++; $display("FAIL single_roll_grant got=%b exp=0", rollover_flag); end
    m_last        = 2;
    bus.src_valid = '0;
    tick();
    checks++; if (write_ready !== 1'b0 || bus.src_ready !== 4'b0) begin failures++; $display("FAIL single_pulse_width wr=%b rdy=%b exp 0/0", write_ready, bus.src_ready); end
    for (int s = 1; s <= 3; s++) begin
      repeat (6) tick();
      strobe();
      checks++; if (rollover_flag !== (s == 2)) begin failures++; $display("FAIL single_roll_s%0d got=%b exp=%b", s, rollover_flag, (s == 2)); end
      checks++; if (busy !== (s < 3)) begin failures++; $display("FAIL single_busy_s%0d got=%b exp=%b", s, busy, (s < 3)); end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_dat;
    logic [3:0]  exp_oh;
    int          w;
    apply_reset();
    frames        = 16'd1;
    bus.src_valid = 4'hF;
    for (int i = 0; i < NUM_SRC; i++) bus.src_data[i] = $urandom;
    for (int g = 0; g < 5; g++) begin
      w       = pick(bus.src_valid, m_last);
      exp_oh  = 4'(1 << w);
      exp_dat = bus.src_data[w];
      tick();
      checks++; if (w != g % NUM_SRC) begin failures++; $display("FAIL rr_model_order got=%0d exp=%0d", w, g % NUM_SRC); end
      checks++; if (bus.src_ready !== exp_oh) begin failures++; $display("FAIL rr_grant_%0d got=%b exp=%b", g, bus.src_ready, exp_oh); end
      checks++; if (writeback !== exp_dat) begin failures++; $display("FAIL rr_data_%0d got=%h exp=%h", g, writeback, exp_dat); end
      checks++; if (rollover_flag !== 1'b1) begin failures++; $display("FAIL rr_roll_%0d got=%b exp=1", g, rollover_flag); end
      m_last          = w;
      bus.src_data[w] = $urandom;
      repeat (3) begin
        tick();
        checks++; if (bus.src_ready !== 4'b0 || write_ready !== 1'b0) begin failures++; $display("FAIL rr_no_grant_busy rdy=%b wr=%b exp 0/0", bus.src_ready, write_ready); end
      end
      strobe();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_%0d busy=%b exp=0", g, busy); end
    end
    bus.src_valid = '0;
    tick();
  endtask

  task automatic test_frames01();
    int w;
    for (int f = 0; f < 2; f++) begin
      frames        = 16'(f);
      bus.src_valid = 4'(1 << $urandom_range(0, 3));
      w             = pick(bus.src_valid, m_last);
      tick();
      checks++; if (write_ready !== 1'b1 || active_src !== 2'(w)) begin failures++; $display("FAIL f%0d_grant wr=%b act=%0d exp 1/%0d", f, write_ready, active_src, w); end
      checks++; if (rollover_flag !== 1'b1) begin failures++; $display("FAIL f%0d_roll got=%b exp=1", f, rollover_flag); end
      m_last        = w;
      bus.src_valid = '0;
      repeat (2) tick();
      strobe();
      checks++; if (busy !== 1'b0 || rollover_flag !== 1'b0) begin failures++; $display("FAIL f%0d_idle busy=%b roll=%b exp 0/0", f, busy, rollover_flag); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] wb;
    frames          = 16'd2;
    hold            = 1'b1;
    bus.src_valid   = 4'b1000;
    bus.src_data[3] = $urandom;
    wb              = bus.src_data[3];
    tick();
    checks++; if (write_ready !== 1'b1 || rollover_flag !== 1'b0) begin failures++; $display("FAIL hold_grant wr=%b roll=%b exp 1/0", write_ready, rollover_flag); end
    m_last        = 3;
    bus.src_valid = '0;
    for (int s = 0; s < 5; s++) begin
      repeat (3) tick();
      strobe();
      checks++; if (rollover_flag !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL hold_s%0d roll=%b busy=%b exp 0/1", s, rollover_flag, busy); end
      checks++; if (writeback !== wb) begin failures++; $display("FAIL hold_wb_s%0d got=%h exp=%h", s, writeback, wb); end
    end
    hold = 1'b0;
    tick();
    strobe();
    checks++; if (rollover_flag !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL hold_release roll=%b busy=%b exp 1/1", rollover_flag, busy); end
    strobe();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_end busy=%b exp=0", busy); end
  endtask

  task automatic test_boundary();
    logic [31:0] wb;
    int          w;
    frames        = 16'd1;
    bus.src_valid = 4'b1000;
    w             = pick(bus.src_valid, m_last);
    tick();
    m_last        = w;
    bus.src_valid = '0;
    repeat (5) tick();
    bus.src_valid   = 4'b0010;
    bus.src_data[1] = $urandom;
    shift_strobe    = 1'b1;
    tick();
    shift_strobe    = 1'b0;
    checks++; if (busy !== 1'b0 || write_ready !== 1'b0 || bus.src_ready !== 4'b0) begin failures++; $display("FAIL bnd_no_grant busy=%b wr=%b rdy=%b exp 0/0/0", busy, write_ready, bus.src_ready); end
    tick();
    checks++; if (bus.src_ready !== 4'b0010 || write_ready !== 1'b1 || active_src !== 2'd1) begin failures++; $display("FAIL bnd_grant rdy=%b wr=%b act=%0d exp 0010/1/1", bus.src_ready, write_ready, active_src); end
    checks++; if (writeback !== bus.src_data[1]) begin failures++; $display("FAIL bnd_data got=%h exp=%h", writeback, bus.src_data[1]); end
    m_last        = 1;
    bus.src_valid = '0;
    tick();
    checks++; if (write_ready !== 1'b0) begin failures++; $display("FAIL bnd_pulse wr=%b exp=0", write_ready); end
    strobe();
    wb = writeback;
    tick();
    strobe();
    tick();
    checks++; if (busy !== 1'b0 || rollover_flag !== 1'b0 || write_ready !== 1'b0 || writeback !== wb) begin failures++; $display("FAIL bnd_spurious busy=%b roll=%b wr=%b wb=%h exp 0/0/0/%h", busy, rollover_flag, write_ready, writeback, wb); end
  endtask

  task automatic test_reset_mid();
    frames        = 16'd3;
    bus.src_valid = 4'b0100;
    tick();
    bus.src_valid = '0;
    repeat (3) tick();
    strobe();
    repeat (2) tick();
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || writeback !== 32'h0 || write_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_a busy=%b wb=%h wr=%b exp 0", busy, writeback, write_ready); end
    checks++; if (rollover_flag !== 1'b0 || active_src !== 2'd0 || bus.src_ready !== 4'b0) begin failures++; $display("FAIL mid_reset_b roll=%b act=%0d rdy=%b exp 0", rollover_flag, active_src, bus.src_ready); end
    tick();
    n_rst         = 1'b1;
    m_last        = NUM_SRC - 1;
    bus.src_valid = 4'b0101;
    tick();
    checks++; if (bus.src_ready !== 4'b0001 || active_src !== 2'd0) begin failures++; $display("FAIL mid_reset_regrant rdy=%b act=%0d exp 0001/0", bus.src_ready, active_src); end
    m_last        = 0;
    bus.src_valid = '0;
    repeat (3) strobe();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_end busy=%b exp=0", busy); end
  endtask

  task automatic test_random();
    logic [3:0]  mask;
    logic [31:0] exp_dat;
    int          w, fe, k;
    bit          exp_roll, done;
    apply_reset();
    for (int v = 0; v < 40; v++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.src_valid = '0;
        tick();
        checks++; if (write_ready !== 1'b0) begin failures++; $display("FAIL rnd_idle_nogrant wr=%b exp=0", write_ready); end
      end
      mask          = 4'($urandom_range(1, 15));
      bus.src_valid = mask;
      for (int i = 0; i < NUM_SRC; i++) bus.src_data[i] = $urandom;
      frames        = 16'($urandom_range(0, 4));
      hold          = ($urandom_range(0, 3) == 0);
      fe            = (frames == 0) ? 1 : int'(frames);
      w             = pick(mask, m_last);
      exp_dat       = bus.src_data[w];
      exp_roll      = (fe == 1) && !hold;
      tick();
      checks++; if (bus.src_ready !== 4'(1 << w) || active_src !== 2'(w)) begin failures++; $display("FAIL rnd_grant_%0d rdy=%b act=%0d exp src %0d", v, bus.src_ready, active_src, w); end
      checks++; if (writeback !== exp_dat || write_ready !== 1'b1) begin failures++; $display("FAIL rnd_data_%0d wb=%h wr=%b exp %h/1", v, writeback, write_ready, exp_dat); end
      checks++; if (rollover_flag !== exp_roll) begin failures++; $display("FAIL rnd_roll_grant_%0d got=%b exp=%b", v, rollover_flag, exp_roll); end
      m_last        = w;
      bus.src_valid = '0;
      k             = 0;
      done          = 0;
      for (int s = 0; s < 20 && !done; s++) begin
        repeat ($urandom_range(0, 3)) tick();
        hold = (s < 10) && ($urandom_range(0, 3) == 0);
        strobe();
        if (exp_roll) begin
          exp_roll = 0;
          done     = 1;
        end else begin
          k++;
          exp_roll = !hold && (k >= fe - 1);
        end
        checks++; if (rollover_flag !== exp_roll || busy !== !done) begin failures++; $display("FAIL rnd_strobe_%0d_%0d roll=%b busy=%b exp %b/%b", v, s, rollover_flag, busy, exp_roll, !done); end
        checks++; if (bus.src_ready !== 4'b0) begin failures++; $display("FAIL rnd_ready_in_show rdy=%b exp=0", bus.src_ready); end
      end
      checks++; if (!done) begin failures++; $display("FAIL rnd_no_return_%0d busy=%b exp=0", v, busy); end
      hold = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_last   = NUM_SRC - 1;
    test_reset();
    test_single();
    test_round_robin();
    test_frames01();
    test_hold();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_sched.md
Name: display_sched

Overview:
- Scheduler and arbiter in front of the 8-digit seven-segment scan FSM.
- Shares that single display between NUM_SRC requesters using round-robin arbitration.
- Latches the granted 32-bit word onto `writeback` and pulses `write_ready` to start the scan.
- Counts completed 8-digit frames via `shift_strobe` and raises `rollover_flag` so the scan FSM stops after the configured number of frames.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- FRAME_W, 16, width of the frames-per-value count.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- src_valid  in  NUM_SRC  per-source request; held with data until accepted
- src_data  in  NUM_SRC x 32  per-source display word
- src_ready  out  NUM_SRC  one-hot, one-cycle accept pulse
- frames  in  FRAME_W  full 8-digit frames to show per value; 0 is treated as 1
- hold  in  1  freeze on the current value (suppress rollover)
- shift_strobe  in  1  one-cycle pulse from the scan FSM, asserted the cycle after the last digit of each frame
- writeback  out  32  word driven to the scan FSM
- write_ready  out  1  one-cycle start pulse to the scan FSM
- rollover_flag  out  1  level; high means the current frame is the last one
- active_src  out  $clog2(NUM_SRC)  index of the source being shown
- busy  out  1  high while in SHOW

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, writeback 0, write_ready 0, src_ready 0, rollover_flag 0, active_src 0, busy 0, frame_cnt 0, last_grant NUM_SRC-1 (so source 0 wins first).
- Reset mid-operation aborts immediately. The scan FSM shares n_rst, so both restart together.
- State IDLE:
  - Shift_strobe is ignored.
  - If any src_valid is high at edge t, the winner is the first valid index searching upward from last_grant+1, wrapping modulo NUM_SRC.
  - At edge t the block registers: writeback <= src_data[winner]; src_ready[winner] pulses 1 cycle; write_ready pulses 1 cycle; active_src and last_grant <= winner.
  - Also at edge t: frames_eff <= max(frames,1), latched so later `frames` changes do not affect this value; frame_cnt <= 0; rollover_flag <= (frames_eff==1) && !hold; busy <= 1; state <= SHOW.
- State SHOW:
  - write_ready and src_ready are 0. New requests wait, and src_valid is not sampled for grant.
  - rollover_flag updates only at grant and on shift_strobe edges. It is therefore stable from the scan FSM's last-digit cycle through the following strobe.
  - On shift_strobe with rollover_flag==1: state <= IDLE, rollover_flag <= 0, busy <= 0. A new grant is possible on the next cycle.
  - On shift_strobe with rollover_flag==0: frame_cnt <= saturating frame_cnt+1; rollover_flag <= (frame_cnt+1 >= frames_eff-1) && !hold.
  - hold high: the value repeats indefinitely. hold takes effect and is released only at frame boundaries; the next frame after release is the last.
- Latency: src_valid high in IDLE at cycle t -> src_ready, write_ready and writeback at t+1. The scan FSM's first digit appears on its outputs at t+3.
- Total display time per value: frames_eff x 8 cycles plus scan-start overhead.
- Simultaneous requests: exactly one grant per value. Fairness: any continuously valid source is granted within NUM_SRC grants.
- A source that drops src_valid before its grant is skipped and nothing is latched for it.
- frame_cnt saturates at 2^FRAME_W-1 and never wraps.

Decomposition:
- Package display_pkg: sched_state_t enum {IDLE, SHOW}; DIGITS=8; shared with the scan FSM and digit counter.
- One sub-module, rr_arbiter: combinational round-robin pick (req vector, last_grant -> grant one-hot, any).
- All state and counters stay in display_sched.

Test Plan:
- Reset mid-SHOW: assert n_rst low during frame 2 of 3 -> all outputs 0 asynchronously; after release, a valid src0 is granted again first.
- Single source: src_valid[2]=1, src_data[2]=32'hDEADBEEF, frames=3 -> src_ready[2] and write_ready one cycle at t+1, writeback=DEADBEEF. rollover_flag rises after the 2nd shift_strobe; IDLE after the 3rd; busy high for exactly 3 frames.
- Round-robin: all 4 sources valid, frames=1 -> grant order 0,1,2,3,0. Each src_ready pulses once per value, with no grant while busy.
- frames=0 and frames=1: both give rollover_flag=1 at grant and return to IDLE on the first shift_strobe.
- hold: frames=2, hold=1 through 5 strobes -> rollover_flag stays 0 and writeback is unchanged. Drop hold -> rollover_flag=1 after the next strobe; IDLE on the following strobe.
- Boundary: src_valid[1] rises in the same cycle the final shift_strobe arrives -> no grant that cycle; grant at the next IDLE cycle with write_ready one cycle later. A spurious shift_strobe in IDLE causes no state change.
